fifo_consumer: RTL and testbench

//   Read-side stage of async_fifo, mirroring the write-side producer.

---
 rtl/fifo_consumer.sv | 81 ++++++++
 tb/tb_fifo_consumer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_consumer.sv
// Read-side drain stage for an async FIFO: pops words into a small circular
// buffer that hides the FIFO read latency, then hands them downstream on valid/ready.
module fifo_consumer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [OCC_W-1:0]      occ_reg;
  logic [OCC_W-1:0]      occ_next;
  logic                  inflight_reg;
  logic [CNT_WIDTH-1:0]  rd_count_reg;
  logic                  capture;
  logic                  pop;
  logic [OCC_W:0]        committed;

  // Words already held plus the one the FIFO is still returning; issuing only
  // while this is below the depth guarantees every returned word has a slot.
  assign committed = {1'b0, occ_reg} + {{OCC_W{1'b0}}, inflight_reg};
  assign r_en      = !rrst && !r_empty && (committed < DEPTH_L);

  assign capture   = inflight_reg;
  assign out_valid = (occ_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? buf_mem[rd_ptr_reg] : '0;
  assign rd_count  = rd_count_reg;

  always_comb begin
    occ_next = occ_reg;
    case ({capture, pop})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      occ_reg      <= '0;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_count_reg <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= r_en;
      if (capture) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        rd_count_reg <= rd_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset: out_data is masked while the buffer is empty.
  always_ff @(posedge r_clk) begin
    if (capture && !rrst) begin
      buf_mem[wr_ptr_reg] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_consumer.sv
// Randomised and directed bench for fifo_consumer, checked every cycle against
// a queue-based model of the FIFO, the in-flight word and the held words.
module tb_fifo_consumer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          r_clk;
  logic          rrst;
  logic          r_empty;
  logic [DW-1:0] fifo_dout;
  logic          r_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    rd_count;
  logic          r_en16;
  logic [DW-1:0] out_data16;
  logic          out_valid16;
  logic [15:0]   rd_count16;

  fifo_consumer #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(4)) dut (
    .r_clk(r_clk), .rrst(rrst), .r_empty(r_empty), .fifo_dout(fifo_dout),
    .r_en(r_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rd_count(rd_count)
  );

  fifo_consumer #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(16)) dut16 (
    .r_clk(r_clk), .rrst(rrst), .r_empty(r_empty), .fifo_dout(fifo_dout),
    .r_en(r_en16), .out_data(out_data16), .out_valid(out_valid16),
    .out_ready(out_ready), .rd_count(rd_count16)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // Model state: words waiting in the FIFO, words held by the consumer, and
  // the word the FIFO returns next cycle after a pop.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] held[$];
  logic [DW-1:0] got[$];
  bit            pend;
  logic [DW-1:0] pend_word;
  int            m_cnt;

  bit rst_i, rdy_i, stall_i;
  int cyc;
  int n_chk, n_fail;

  logic          s_ren, s_valid;
  logic [DW-1:0] s_data;
  logic [3:0]    s_cnt;
  logic [15:0]   s_cnt16;
  int            s_cyc;
  bit            popped_now;
  logic [DW-1:0] pop_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit do_chk);
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_ren;
    @(negedge r_clk);
    rrst      = rst_i;
    out_ready = rdy_i;
    r_empty   = (fifo_q.size() == 0) || stall_i;
    fifo_dout = pend ? pend_word : DW'($urandom);
    #1;
    e_valid = (held.size() != 0);
    e_data  = e_valid ? held[0] : '0;
    e_ren   = !rst_i && !r_empty && ((held.size() + int'(pend)) < DEPTH);
    s_ren = r_en; s_valid = out_valid; s_data = out_data;
    s_cnt = rd_count; s_cnt16 = rd_count16; s_cyc = cyc;
    if (do_chk) begin
      chk("r_en", {31'b0, r_en}, {31'b0, e_ren});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
      chk("out_data", out_data, e_data);
      chk("rd_count", {28'b0, rd_count}, m_cnt % 16);
      chk("rd_count16", {16'b0, rd_count16}, m_cnt % 65536);
    end
    popped_now = 1'b0;
    if (rst_i) begin
      held.delete();
      pend  = 1'b0;
      m_cnt = 0;
    end else begin
      if (e_valid && rdy_i) begin
        void'(held.pop_front());
        m_cnt++;
        popped_now = 1'b1;
        pop_data   = e_data;
        $display("pop cyc=%0d data=%h count=%0d", cyc, e_data, m_cnt);
      end
      if (pend) held.push_back(pend_word);
      pend = e_ren;
      if (e_ren) pend_word = fifo_q.pop_front();
    end
    cyc++;
  endtask

  initial begin
    int ren_c, val_c, n_ren, cnt_at, first_c, last_c, first_w;
    logic [DW-1:0] val_d;
    bit found;
    n_chk = 0; n_fail = 0; cyc = 0; m_cnt = 0; pend = 1'b0; pend_word = '0;
    rst_i = 1'b1; rdy_i = 1'b0; stall_i = 1'b0;
    rrst = 1'b1; r_empty = 1'b0; out_ready = 1'b0; fifo_dout = '0;
    popped_now = 1'b0; pop_data = '0;

    // Reset with data available: nothing may be issued or presented.
    fifo_q.push_back(32'hDEAD_0000);
    cycle(0);
    repeat (3) begin
      cycle(1);
      chk("reset_r_en", {31'b0, s_ren}, 0);
      chk("reset_valid", {31'b0, s_valid}, 0);
      chk("reset_count", {16'b0, s_cnt16}, 0);
    end
    fifo_q.delete();

    // Single word latency.
    fifo_q.push_back(32'hA5A5_0001);
    rst_i = 1'b0; rdy_i = 1'b1;
    ren_c = -1; val_c = -1; n_ren = 0; cnt_at = -1; val_d = '0;
    repeat (8) begin
      cycle(1);
      if (s_ren) begin
        n_ren++;
        if (ren_c < 0) ren_c = s_cyc;
      end
      if (s_valid && val_c < 0) begin
        val_c = s_cyc;
        val_d = s_data;
      end
      if (ren_c >= 0 && s_cyc == ren_c + 3) cnt_at = int'(s_cnt16);
    end
    chk("single_ren_pulses", n_ren, 1);
    chk("single_latency", val_c - ren_c, 2);
    chk("single_data", val_d, 32'hA5A5_0001);
    chk("single_count_n3", cnt_at, 1);

    // Streaming at one word per cycle; 17 total deliveries also wraps the 4-bit counter.
    for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(i));
    first_c = -1; last_c = -1;
    for (int k = 0; k < 40 && m_cnt < 17; k++) begin
      cycle(1);
      if (popped_now) begin
        if (first_c < 0) first_c = s_cyc;
        last_c = s_cyc;
      end
    end
    cycle(1);
    chk("stream_rate", last_c - first_c, 15);
    chk("stream_count16", {16'b0, s_cnt16}, 17);
    chk("wrap_count4", {28'b0, s_cnt}, 1);

    // Backpressure: only DEPTH words may be requested while stalled.
    rdy_i = 1'b0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(100 + i));
    n_ren = 0;
    repeat (10) begin
      cycle(1);
      if (s_ren) n_ren++;
    end
    chk("bp_ren_pulses", n_ren, 4);
    chk("bp_hold_data", s_data, 100);
    chk("bp_hold_valid", {31'b0, s_valid}, 1);
    rdy_i = 1'b1;
    got.delete();
    for (int k = 0; k < 40 && got.size() < 10; k++) begin
      cycle(1);
      if (popped_now) got.push_back(pop_data);
    end
    chk("bp_drained", got.size(), 10);
    foreach (got[i]) chk("bp_order", got[i], 100 + i);

    // Reset while three words are held and one is in flight.
    rdy_i = 1'b0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(200 + i));
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (held.size() == 3 && pend) begin
        found = 1'b1;
        break;
      end
      cycle(1);
    end
    chk("midrst_setup", {31'b0, found}, 1);
    rst_i = 1'b1;
    cycle(1);
    rst_i = 1'b0;
    cycle(1);
    chk("midrst_valid", {31'b0, s_valid}, 0);
    chk("midrst_count16", {16'b0, s_cnt16}, 0);
    chk("midrst_count4", {28'b0, s_cnt}, 0);
    rdy_i = 1'b1;
    first_w = -1;
    for (int k = 0; k < 40 && first_w < 0; k++) begin
      cycle(1);
      if (popped_now) first_w = int'(pop_data);
    end
    chk("midrst_first_word", first_w, 204);

    // Random traffic, stalls, backpressure and occasional resets.
    repeat (3000) begin
      rdy_i   = ($urandom_range(3) != 0);
      stall_i = ($urandom_range(4) == 0);
      rst_i   = ($urandom_range(399) == 0);
      if (fifo_q.size() < 8 && $urandom_range(1) == 1) fifo_q.push_back(DW'($urandom));
      cycle(1);
    end
    rst_i = 1'b0; rdy_i = 1'b1; stall_i = 1'b0;
    for (int k = 0; k < 60 && (fifo_q.size() != 0 || held.size() != 0 || pend); k++) cycle(1);
    chk("drain_done", fifo_q.size() + held.size() + int'(pend), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
